// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP64 PI controller sequencer: FSM states,
// default external-unit latencies, IEEE-754 double constants and compare helpers.
package fp_ctrl_pkg;

    typedef enum logic [3:0] {
        IDLE,
        MUL0,
        MUL1,
        WMUL,
        ADD1,
        WADD1,
        ADD2,
        WADD2,
        SAT,
        OUT
    } state_t;

    localparam int unsigned DEF_MUL_LAT = 11;
    localparam int unsigned DEF_ADD_LAT = 14;

    localparam logic [63:0] FP64_ZERO  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FP64_ONE   = 64'h3FF0_0000_0000_0000;
    localparam logic [63:0] FP64_POS10 = 64'h4024_0000_0000_0000;
    localparam logic [63:0] FP64_NEG10 = 64'hC024_0000_0000_0000;

    // Maps a double onto an unsigned key whose ordering matches numeric order;
    // both signed zeros share one key so they compare equal.
    function automatic logic [63:0] fp64_key(input logic [63:0] x);
        logic [63:0] k;
        if (x[62:0] == 63'd0) begin
            k = 64'h8000_0000_0000_0000;
        end else if (x[63]) begin
            k = ~x;
        end else begin
            k = {1'b1, x[62:0]};
        end
        return k;
    endfunction

    function automatic logic fp64_is_special(input logic [63:0] x);
        return &x[62:52];
    endfunction

endpackage

// File: rtl/fp64_clamp.sv
// Combinational IEEE-754 double clamp: y = min(max(x, lo), hi) using a
// sign-magnitude ordering in which -0.0 and +0.0 are equal.
module fp64_clamp
    import fp_ctrl_pkg::*;
(
    input  logic [63:0] x,
    input  logic [63:0] lo,
    input  logic [63:0] hi,
    output logic [63:0] y
);

    logic [63:0] x_key;
    logic [63:0] lo_key;
    logic [63:0] hi_key;

    always_comb begin
        x_key  = fp64_key(x);
        lo_key = fp64_key(lo);
        hi_key = fp64_key(hi);
        if (x_key > hi_key) begin
            y = hi;
        end else if (x_key < lo_key) begin
            y = lo;
        end else begin
            y = x;
        end
    end

endmodule

// File: rtl/pi_fp_seq.sv
// Sequences one PI update u[n] = clamp(u[n-1] + B0*e[n] + B1*e[n-1]) through an
// external pipelined FP64 multiplier and adder, one sample at a time.
module pi_fp_seq
    import fp_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = DEF_MUL_LAT,
    parameter int unsigned ADD_LAT = DEF_ADD_LAT,
    parameter logic [63:0] B0      = FP64_ONE,
    parameter logic [63:0] B1      = FP64_ZERO,
    parameter logic [63:0] UMAX    = FP64_POS10,
    parameter logic [63:0] UMIN    = FP64_NEG10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] e0,
    input  logic        e0ready,
    output logic [63:0] mula,
    output logic [63:0] mulb,
    input  logic [63:0] mulr,
    output logic [63:0] adda,
    output logic [63:0] addb,
    input  logic [63:0] addr,
    output logic [63:0] u,
    output logic        uready,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned MAX_LAT = (MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT;
    localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam logic [CNT_W-1:0] MUL_WAIT = CNT_W'(MUL_LAT - 1);
    localparam logic [CNT_W-1:0] ADD_WAIT = CNT_W'(ADD_LAT - 1);

    state_t           state_q,   state_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [63:0]      u_q,       u_d;
    logic [63:0]      u_prev_q,  u_prev_d;
    logic [63:0]      e_prev_q,  e_prev_d;
    logic             uready_q,  uready_d;
    logic             busy_q,    busy_d;
    logic             overrun_q, overrun_d;
    logic [63:0]      e_n_q,     e_n_d;
    logic [63:0]      p0_q,      p0_d;
    logic [63:0]      p1_q,      p1_d;
    logic [63:0]      s_q,       s_d;
    logic [63:0]      r_q,       r_d;
    logic [63:0]      u_sat;

    fp64_clamp u_clamp (
        .x  (r_q),
        .lo (UMIN),
        .hi (UMAX),
        .y  (u_sat)
    );

    always_comb begin
        // NOTE: every signal gets its default before the case so no path can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        u_d       = u_q;
        u_prev_d  = u_prev_q;
        e_prev_d  = e_prev_q;
        uready_d  = 1'b0;
        overrun_d = overrun_q;
        e_n_d     = e_n_q;
        p0_d      = p0_q;
        p1_d      = p1_q;
        s_d       = s_q;
        r_d       = r_q;

        if (e0ready && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (e0ready) begin
                    if (fp64_is_special(e0)) begin
                        overrun_d = 1'b1;
                    end else begin
                        e_n_d   = e0;
                        state_d = MUL0;
                    end
                end
            end
            MUL0: state_d = MUL1;
            MUL1: begin
                // With a single-cycle multiplier the B0 product is already back.
                if (MUL_LAT == 1) begin
                    p0_d = mulr;
                end
                cnt_d   = MUL_WAIT;
                state_d = WMUL;
            end
            WMUL: begin
                if (cnt_q == CNT_W'(1)) begin
                    p0_d = mulr;
                end
                if (cnt_q == '0) begin
                    p1_d    = mulr;
                    state_d = ADD1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADD1: begin
                cnt_d   = ADD_WAIT;
                state_d = WADD1;
            end
            WADD1: begin
                if (cnt_q == '0) begin
                    s_d     = addr;
                    state_d = ADD2;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ADD2: begin
                cnt_d   = ADD_WAIT;
                state_d = WADD2;
            end
            WADD2: begin
                if (cnt_q == '0) begin
                    r_d     = addr;
                    state_d = SAT;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            SAT: begin
                u_d      = u_sat;
                uready_d = 1'b1;
                state_d  = OUT;
            end
            OUT: begin
                u_prev_d = u_q;
                e_prev_d = e_n_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    // Operands are a pure decode of the state so they stay put through each wait.
    always_comb begin
        mula = '0;
        mulb = '0;
        adda = '0;
        addb = '0;
        case (state_q)
            MUL0: begin
                mula = e_n_q;
                mulb = B0;
            end
            MUL1, WMUL: begin
                mula = e_prev_q;
                mulb = B1;
            end
            ADD1, WADD1: begin
                adda = p0_q;
                addb = p1_q;
            end
            ADD2, WADD2: begin
                adda = s_q;
                addb = u_prev_q;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            u_q       <= '0;
            u_prev_q  <= '0;
            e_prev_q  <= '0;
            uready_q  <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            u_q       <= u_d;
            u_prev_q  <= u_prev_d;
            e_prev_q  <= e_prev_d;
            uready_q  <= uready_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: datapath holding registers carry no reset; each is written before any state reads it.
    always_ff @(posedge clk) begin
        e_n_q <= e_n_d;
        p0_q  <= p0_d;
        p1_q  <= p1_d;
        s_q   <= s_d;
        r_q   <= r_d;
    end

    assign u       = u_q;
    assign uready  = uready_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_pi_fp_seq.sv
// Bench for pi_fp_seq: behavioural FP64 multiplier/adder pipelines and a
// real-arithmetic PI reference model; instance 1 uses B1 = -1.0.
module tb_pi_fp_seq;
    import fp_ctrl_pkg::*;

    localparam int MUL_LAT = 11;
    localparam int ADD_LAT = 14;
    localparam int LAT     = MUL_LAT + 2 * ADD_LAT + 6;
    localparam int NI      = 2;
    localparam logic [63:0] FP64_TWO  = 64'h4000_0000_0000_0000;
    localparam logic [63:0] FP64_MONE = 64'hBFF0_0000_0000_0000;
    localparam logic [63:0] FP64_NAN  = 64'h7FF8_0000_0000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        e0ready;
    logic [63:0] e0;
    logic [63:0] mula [NI];
    logic [63:0] mulb [NI];
    logic [63:0] mulr [NI];
    logic [63:0] adda [NI];
    logic [63:0] addb [NI];
    logic [63:0] addr [NI];
    logic [63:0] u    [NI];
    logic        uready  [NI];
    logic        busy    [NI];
    logic        overrun [NI];

    int vecs = 0;
    int errs = 0;
    int ready_cnt [NI] = '{default: 0};

    real m_u  [NI];
    real m_ep [NI];
    real m_b0 [NI] = '{1.0, 1.0};
    real m_b1 [NI] = '{0.0, -1.0};

    logic [63:0] mul_pipe [NI][MUL_LAT];
    logic [63:0] add_pipe [NI][ADD_LAT];

    always #5 clk = ~clk;

    pi_fp_seq u_dut0 (
        .clk(clk), .rst(rst), .e0(e0), .e0ready(e0ready),
        .mula(mula[0]), .mulb(mulb[0]), .mulr(mulr[0]),
        .adda(adda[0]), .addb(addb[0]), .addr(addr[0]),
        .u(u[0]), .uready(uready[0]), .busy(busy[0]), .overrun(overrun[0])
    );

    pi_fp_seq #(.B1(FP64_MONE)) u_dut1 (
        .clk(clk), .rst(rst), .e0(e0), .e0ready(e0ready),
        .mula(mula[1]), .mulb(mulb[1]), .mulr(mulr[1]),
        .adda(adda[1]), .addb(addb[1]), .addr(addr[1]),
        .u(u[1]), .uready(uready[1]), .busy(busy[1]), .overrun(overrun[1])
    );

    // Exact-latency behavioural FP units built on the simulator's IEEE doubles.
    always @(posedge clk) begin
        for (int k = 0; k < NI; k++) begin
            mul_pipe[k][0] <= $realtobits($bitstoreal(mula[k]) * $bitstoreal(mulb[k]));
            for (int i = 1; i < MUL_LAT; i++) mul_pipe[k][i] <= mul_pipe[k][i-1];
            add_pipe[k][0] <= $realtobits($bitstoreal(adda[k]) + $bitstoreal(addb[k]));
            for (int i = 1; i < ADD_LAT; i++) add_pipe[k][i] <= add_pipe[k][i-1];
            if (uready[k]) ready_cnt[k] <= ready_cnt[k] + 1;
        end
    end

    assign mulr[0] = mul_pipe[0][MUL_LAT-1];
    assign mulr[1] = mul_pipe[1][MUL_LAT-1];
    assign addr[0] = add_pipe[0][ADD_LAT-1];
    assign addr[1] = add_pipe[1][ADD_LAT-1];

    function automatic void model_reset();
        for (int k = 0; k < NI; k++) begin
            m_u[k]  = 0.0;
            m_ep[k] = 0.0;
        end
    endfunction

    function automatic void model_accept(input logic [63:0] ev);
        real r;
        for (int k = 0; k < NI; k++) begin
            r = m_u[k] + (m_b0[k] * $bitstoreal(ev) + m_b1[k] * m_ep[k]);
            if (r > 10.0) r = 10.0;
            else if (r < -10.0) r = -10.0;
            m_u[k]  = r;
            m_ep[k] = $bitstoreal(ev);
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; e0ready = 1'b0; e0 = '0;
        tick(); tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic send(input logic [63:0] ev);
        e0 = ev; e0ready = 1'b1;
        tick();
        e0ready = 1'b0;
    endtask

    task automatic wait_ready(input int start, input int limit, output int n, output bit seen);
        n = start; seen = 1'b0;
        while (n < limit && !seen) begin
            tick();
            n++;
            if (uready[0]) seen = 1'b1;
        end
    endtask

    task automatic run_sample(input logic [63:0] ev, output int n, output bit seen,
                              output logic [63:0] got0, output logic [63:0] got1);
        model_accept(ev);
        send(ev);
        wait_ready(1, LAT + 20, n, seen);
        got0 = u[0]; got1 = u[1];
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        vecs++; if (u[0] !== 64'h0)   begin errs++; $display("FAIL rst_u: got %h want 0", u[0]); end
        vecs++; if (uready[0] !== 1'b0) begin errs++; $display("FAIL rst_uready: got %b want 0", uready[0]); end
        vecs++; if (busy[0] !== 1'b0)   begin errs++; $display("FAIL rst_busy: got %b want 0", busy[0]); end
        vecs++; if (overrun[0] !== 1'b0) begin errs++; $display("FAIL rst_overrun: got %b want 0", overrun[0]); end
        vecs++; if ({mula[0], mulb[0], adda[0], addb[0]} !== 256'h0)
            begin errs++; $display("FAIL rst_operands: got %h %h %h %h want 0", mula[0], mulb[0], adda[0], addb[0]); end
        rst = 1'b1; e0 = FP64_ONE; e0ready = 1'b1;
        tick();
        rst = 1'b0; e0ready = 1'b0;
        tick();
        vecs++; if (busy[0] !== 1'b0) begin errs++; $display("FAIL rst_strobe_discard: busy got %b want 0", busy[0]); end
    endtask

    task automatic test_latency();
        int n; bit seen; logic [63:0] g0, g1;
        do_reset();
        model_accept(FP64_ONE);
        send(FP64_ONE);
        vecs++; if (busy[0] !== 1'b1) begin errs++; $display("FAIL lat_busy_start: got %b want 1", busy[0]); end
        vecs++; if (mula[0] !== FP64_ONE || mulb[0] !== FP64_ONE)
            begin errs++; $display("FAIL lat_mul0_ops: got %h %h want %h %h", mula[0], mulb[0], FP64_ONE, FP64_ONE); end
        wait_ready(1, LAT + 20, n, seen);
        vecs++; if (!seen || n != LAT) begin errs++; $display("FAIL lat_cycles: got %0d (seen %b) want %0d", n, seen, LAT); end
        vecs++; if (u[0] !== $realtobits(m_u[0])) begin errs++; $display("FAIL lat_u1: got %h want %h", u[0], $realtobits(m_u[0])); end
        vecs++; if (busy[0] !== 1'b1 || adda[0] !== 64'h0)
            begin errs++; $display("FAIL lat_out_state: busy %b adda %h want 1 0", busy[0], adda[0]); end
        tick();
        vecs++; if (uready[0] !== 1'b0 || busy[0] !== 1'b0)
            begin errs++; $display("FAIL lat_pulse_end: uready %b busy %b want 0 0", uready[0], busy[0]); end
        run_sample(FP64_ONE, n, seen, g0, g1);
        vecs++; if (!seen || g0 !== $realtobits(m_u[0])) begin errs++; $display("FAIL lat_u2: got %h want %h", g0, $realtobits(m_u[0])); end
    endtask

    task automatic test_b1();
        int n; bit seen; logic [63:0] g0, g1;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            run_sample(FP64_TWO, n, seen, g0, g1);
            vecs++; if (!seen || g1 !== $realtobits(m_u[1]))
                begin errs++; $display("FAIL b1_u[%0d]: got %h want %h", i, g1, $realtobits(m_u[1])); end
            vecs++; if (g0 !== $realtobits(m_u[0]))
                begin errs++; $display("FAIL b1_ref_u[%0d]: got %h want %h", i, g0, $realtobits(m_u[0])); end
        end
    endtask

    task automatic test_saturate();
        int n; bit seen; logic [63:0] g0, g1;
        do_reset();
        for (int i = 0; i < 11; i++) begin
            run_sample(FP64_ONE, n, seen, g0, g1);
            vecs++; if (!seen || g0 !== $realtobits(m_u[0]))
                begin errs++; $display("FAIL sat_u[%0d]: got %h want %h", i, g0, $realtobits(m_u[0])); end
        end
        run_sample(FP64_MONE, n, seen, g0, g1);
        vecs++; if (!seen || g0 !== $realtobits(m_u[0]))
            begin errs++; $display("FAIL sat_unwind: got %h want %h", g0, $realtobits(m_u[0])); end
    endtask

    task automatic test_overrun();
        int n; bit seen; int base;
        do_reset();
        base = ready_cnt[0];
        model_accept(FP64_ONE);
        send(FP64_ONE);
        repeat (9) tick();
        e0 = FP64_TWO; e0ready = 1'b1;
        tick();
        e0ready = 1'b0;
        vecs++; if (overrun[0] !== 1'b1 || busy[0] !== 1'b1)
            begin errs++; $display("FAIL ovr_flag: overrun %b busy %b want 1 1", overrun[0], busy[0]); end
        wait_ready(11, LAT + 20, n, seen);
        vecs++; if (!seen || n != LAT || u[0] !== $realtobits(m_u[0]))
            begin errs++; $display("FAIL ovr_result: n %0d u %h want %0d %h", n, u[0], LAT, $realtobits(m_u[0])); end
        repeat (60) tick();
        vecs++; if (ready_cnt[0] - base != 1 || overrun[0] !== 1'b1)
            begin errs++; $display("FAIL ovr_single: pulses %0d overrun %b want 1 1", ready_cnt[0] - base, overrun[0]); end
    endtask

    task automatic test_nan();
        int n; bit seen; logic [63:0] g0, g1; int base;
        do_reset();
        run_sample(FP64_ONE, n, seen, g0, g1);
        base = ready_cnt[0];
        send(FP64_NAN);
        vecs++; if (busy[0] !== 1'b0 || overrun[0] !== 1'b1)
            begin errs++; $display("FAIL nan_reject: busy %b overrun %b want 0 1", busy[0], overrun[0]); end
        repeat (60) tick();
        vecs++; if (ready_cnt[0] != base || u[0] !== $realtobits(m_u[0]))
            begin errs++; $display("FAIL nan_hold: pulses %0d u %h want 0 %h", ready_cnt[0] - base, u[0], $realtobits(m_u[0])); end
    endtask

    task automatic test_rst_mid();
        int n; bit seen; logic [63:0] g0, g1; int base;
        do_reset();
        base = ready_cnt[0];
        send(FP64_ONE);
        repeat (19) tick();
        vecs++; if (adda[0] !== FP64_ONE) begin errs++; $display("FAIL rstmid_wadd1: adda got %h want %h", adda[0], FP64_ONE); end
        rst = 1'b1;
        tick();
        vecs++; if ({u[0], mula[0], mulb[0], adda[0], addb[0]} !== 320'h0 ||
                    {uready[0], busy[0], overrun[0]} !== 3'b000)
            begin errs++; $display("FAIL rstmid_clear: u %h ops %h %h %h %h flags %b%b%b want 0",
                                   u[0], mula[0], mulb[0], adda[0], addb[0], uready[0], busy[0], overrun[0]); end
        rst = 1'b0;
        model_reset();
        repeat (60) tick();
        vecs++; if (ready_cnt[0] != base) begin errs++; $display("FAIL rstmid_no_pulse: got %0d pulses want 0", ready_cnt[0] - base); end
        run_sample(FP64_ONE, n, seen, g0, g1);
        vecs++; if (!seen || n != LAT || g0 !== $realtobits(m_u[0]))
            begin errs++; $display("FAIL rstmid_restart: n %0d u %h want %0d %h", n, g0, LAT, $realtobits(m_u[0])); end
    endtask

    task automatic test_random();
        int cyc, busy_until, due;
        bit strobe, exp_ov, exp_rdy;
        logic [63:0] ev;
        do_reset();
        cyc = 0; busy_until = -1; due = -1; exp_ov = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            strobe = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 9) == 0) ev = 64'h7FF0_0000_0000_0000 | 64'($urandom_range(0, 1));
            else ev = $realtobits(real'(int'($urandom_range(0, 8)) - 4));
            if (strobe) begin
                if (cyc <= busy_until || ev[62:52] == 11'h7FF) begin
                    exp_ov = 1'b1;
                end else begin
                    model_accept(ev);
                    due = cyc + LAT;
                    busy_until = cyc + LAT;
                end
            end
            e0 = ev; e0ready = strobe;
            tick();
            e0ready = 1'b0;
            cyc++;
            exp_rdy = (cyc == due);
            vecs++; if (uready[0] !== exp_rdy || busy[0] !== (cyc <= busy_until))
                begin errs++; $display("FAIL rnd_timing@%0d: uready %b busy %b want %b %b", cyc, uready[0], busy[0], exp_rdy, cyc <= busy_until); end
            if (exp_rdy) begin
                vecs++; if (u[0] !== $realtobits(m_u[0]) || u[1] !== $realtobits(m_u[1]))
                    begin errs++; $display("FAIL rnd_u@%0d: got %h %h want %h %h", cyc, u[0], u[1], $realtobits(m_u[0]), $realtobits(m_u[1])); end
            end
        end
        vecs++; if (overrun[0] !== exp_ov) begin errs++; $display("FAIL rnd_overrun: got %b want %b", overrun[0], exp_ov); end
    endtask

    initial begin
        rst = 1'b1; e0ready = 1'b0; e0 = '0;
        test_reset();
        test_latency();
        test_b1();
        test_saturate();
        test_overrun();
        test_nan();
        test_rst_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/pi_fp_seq.md
PI_FP_SEQ -- requirements
Module: pi_fp_seq

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high, with ports named clk and rst.
REQ-002 Parameters (name, default, meaning) SHALL be:
- MUL_LAT, 11: external FP64 multiplier latency in clk cycles.
- ADD_LAT, 14: external FP64 adder latency in clk cycles.
- B0, 64'h3FF0000000000000: IEEE-754 double coefficient applied to e[n].
- B1, 64'h0000000000000000: coefficient applied to e[n-1].
- UMAX, 64'h4024000000000000: upper clamp, +10.0.
- UMIN, 64'hC024000000000000: lower clamp, -10.0.
REQ-003 Ports (name, direction, width, meaning) SHALL be:
- clk, in, 1: system clock.
- rst, in, 1: sync active-high reset.
- e0, in, 64: IEEE double error sample from the error stage.
- e0ready, in, 1: one-cycle strobe, e0 valid.
- mula, out, 64: multiplier operand A.
- mulb, out, 64: multiplier operand B.
- mulr, in, 64: multiplier result.
- adda, out, 64: adder operand A.
- addb, out, 64: adder operand B.
- addr, in, 64: adder result.
- u, out, 64: control output, IEEE double.
- uready, out, 1: one-cycle strobe, u updated.
- busy, out, 1: high while a sample is in process.
- overrun, out, 1: sticky, a sample was dropped.

Function
REQ-004 The block SHALL compute u[n] = clamp(u[n-1] + B0*e[n] + B1*e[n-1], UMIN, UMAX).
REQ-005 The FSM states SHALL be IDLE, MUL0, MUL1, WMUL, ADD1, WADD1, ADD2, WADD2, SAT, OUT.
REQ-006 In IDLE, e0ready=1 SHALL latch e0 into e_n and go to MUL0; busy SHALL be 1 from the next cycle until OUT inclusive.
REQ-007 MUL0 SHALL drive mula=e_n, mulb=B0; MUL1 SHALL drive mula=e_prev, mulb=B1; mulr SHALL be captured as p0 exactly MUL_LAT cycles after MUL0 and as p1 MUL_LAT cycles after MUL1.
REQ-008 ADD1 SHALL drive adda=p0, addb=p1, capturing s after ADD_LAT cycles; ADD2 SHALL drive adda=s, addb=u_prev, capturing r after ADD_LAT cycles.
REQ-009 All wait states SHALL use a single down-counter loaded with the relevant latency minus one; operands SHALL be held stable for the whole wait.
REQ-010 SAT SHALL clamp r by IEEE sign-magnitude compare: r>UMAX gives UMAX, r<UMIN gives UMIN, else r; -0.0 and +0.0 SHALL compare equal.
REQ-011 OUT SHALL register u, pulse uready for exactly one cycle, update u_prev=u and e_prev=e_n, then return to IDLE.
REQ-012 Latency from the e0ready-high cycle to the uready-high cycle SHALL be MUL_LAT+2*ADD_LAT+6 cycles, which is 45 with defaults; this is well under one clk_Fs period.
REQ-013 e0ready=1 while busy SHALL be ignored and SHALL set overrun; overrun SHALL clear only on rst.
REQ-014 An e0 with exponent all-ones (Inf/NaN) SHALL be rejected in IDLE without starting; state and u are unchanged and overrun is set.
REQ-015 mula, mulb, adda and addb SHALL be 0 outside their drive and wait states.

Reset
REQ-016 On rst, the following SHALL be cleared: u=0, uready=0, busy=0, overrun=0, e_prev=0, u_prev=0, all operand outputs 0, counter 0, state IDLE.
REQ-017 rst asserted mid-sequence SHALL abort without a uready pulse; e0ready coincident with rst SHALL be discarded.

Structure
REQ-018 The FSM state enumeration, the default latencies and the FP64 constants (0.0, 1.0, +/-10.0) SHALL live in shared package fp_ctrl_pkg.
REQ-019 The clamp SHALL be the combinational sub-module fp64_clamp; the FP multiplier and adder are external to this block.

Verification
REQ-020 The bench SHALL model the multiplier and adder behaviourally with exact MUL_LAT and ADD_LAT pipelines and cover:
- Defaults, e0=1.0 (3FF0...0): u=3FF0000000000000 with uready exactly 45 cycles after e0ready; a second e0=1.0 gives u=4000000000000000 (2.0).
- B0=1.0, B1=-1.0 (BFF0...0), e sequence 2.0 then 2.0: u=2.0, then u stays 2.0.
- Eleven samples of 1.0 with defaults: u saturates at 4024000000000000 and holds; then e0=-1.0 gives u=9.0 (4022000000000000).
- e0ready strobed 10 cycles after a first strobe: the second sample is dropped, overrun=1, and exactly one uready follows.
- e0=7FF8000000000000 (NaN): no busy, no uready, overrun=1, u unchanged.
- rst asserted in WADD1: no uready; all outputs read 0 the next cycle; a fresh e0=1.0 gives u=1.0.
